b01_stream_driver: RTL

- Host-side counterpart of the b01 serial flow checker.
- Accepts two parallel operands over a start/ready handshake and drives them LSB-first onto the LINE1/LINE2 serial inputs.
- Deserializes the returned OUTP stream into a parallel RESULT word and accumulates OVERFLW across the frame.
- Sits between a test/control host and the b01 core, with its outputs wired to the core's LINE inputs.

---
 rtl/b01_stream_driver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/b01_stream_driver.sv
// Host-side stream driver for the b01 serial flow checker: serializes two operands
// LSB-first onto LINE1/LINE2 and deserializes the returned OUTP/OVERFLW frame.
module b01_stream_driver #(
    parameter int WIDTH   = 8,
    parameter int RET_LAT = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    output logic             READY,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             LINE1,
    output logic             LINE2,
    input  logic             OUTP,
    input  logic             OVERFLW,
    output logic [WIDTH-1:0] RESULT,
    output logic             RES_OVF,
    output logic             DONE,
    output logic             BUSY
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int CW = $clog2(WIDTH + RET_LAT + 1);
    localparam int KW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(RET_LAT + 2);

    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(WIDTH + RET_LAT - 1);
    localparam logic [KW-1:0] CAP_FULL   = KW'(WIDTH);
    localparam logic [LW-1:0] LAT_INIT   = LW'(RET_LAT);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic             line1_q, line1_d, line2_q, line2_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
    logic [KW-1:0]    cap_cnt_q, cap_cnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             res_ovf_q, res_ovf_d;
    logic             in_window;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        line1_d   = line1_q;
        line2_d   = line2_q;
        tx_cnt_d  = tx_cnt_q;
        lat_cnt_d = lat_cnt_q;
        cap_cnt_d = cap_cnt_q;
        cap_d     = cap_q;
        ovf_acc_d = ovf_acc_q;
        result_d  = result_q;
        res_ovf_d = res_ovf_q;
        in_window = 1'b0;

        // The serializer keeps only the bits not yet driven; LINE holds the current one.
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_SHIFT;
                    line1_d   = OPA[0];
                    line2_d   = OPB[0];
                    sa_d      = {1'b0, OPA[WIDTH-1:1]};
                    sb_d      = {1'b0, OPB[WIDTH-1:1]};
                    tx_cnt_d  = '0;
                    lat_cnt_d = LAT_INIT;
                    cap_cnt_d = '0;
                    cap_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            S_SHIFT: begin
                in_window = 1'b1;
                tx_cnt_d  = tx_cnt_q + CW'(1);
                if (tx_cnt_q == SHIFT_LAST) begin
                    line1_d = 1'b0;
                    line2_d = 1'b0;
                    state_d = (RET_LAT > 0) ? S_DRAIN : S_FIN;
                end else begin
                    line1_d = sa_q[0];
                    line2_d = sb_q[0];
                    sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                    sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                end
            end
            S_DRAIN: begin
                in_window = 1'b1;
                tx_cnt_d  = tx_cnt_q + CW'(1);
                if (tx_cnt_q == DRAIN_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // OUTP trails LINE by RET_LAT cycles; the first RET_LAT window cycles carry no result.
        if (in_window) begin
            if (lat_cnt_q != '0) begin
                lat_cnt_d = lat_cnt_q - LW'(1);
            end else if (cap_cnt_q != CAP_FULL) begin
                cap_d     = {OUTP, cap_q[WIDTH-1:1]};
                cap_cnt_d = cap_cnt_q + KW'(1);
                ovf_acc_d = ovf_acc_q | OVERFLW;
            end
        end

        // The last sample lands on the same edge that enters FIN, so publish the next values.
        if (state_d == S_FIN && state_q != S_FIN) begin
            result_d  = cap_d;
            res_ovf_d = ovf_acc_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            line1_q   <= 1'b0;
            line2_q   <= 1'b0;
            tx_cnt_q  <= '0;
            lat_cnt_q <= '0;
            cap_cnt_q <= '0;
            cap_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            tx_cnt_q  <= tx_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            cap_q     <= cap_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign READY   = (state_q == S_IDLE);
    assign BUSY    = ~READY;
    assign DONE    = (state_q == S_FIN);
    assign LINE1   = line1_q;
    assign LINE2   = line2_q;
    assign RESULT  = result_q;
    assign RES_OVF = res_ovf_q;

endmodule
